keypad_param_loader: RTL and testbench
======================================

# keypad_param_loader

Keypad-driven parameter entry controller sitting between the keypad scan/buffer stage and the motion datapath. It consumes one-cycle key events and sequences a select–digits–enter dialogue. It accumulates a decimal value and commits it to one of four parameter registers (x speed, x place, y speed, y place), with a one-cycle update strobe per register. It is the sole writer of these four parameters.

## Interface
Parameters:
- WIDTH, 10, width of each parameter register and of the entry value.
- DIGITS, 3, maximum decimal digits accepted per entry.
- MAX_VAL, 999, saturation ceiling applied at commit; must be < 2^WIDTH.
- TIMEOUT_CYC, 50_000_000, idle cycles in ENTRY before abort; used only with KEYPAD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle pulse: new key event.
- key_code  in  4  key code, sampled only when key_valid=1. Codes 0–9 are digits, 10 selects xspeed, 11 xplace, 12 yspeed, 13 yplace, 14 is clear, 15 is enter.
- xspeed, xplace, yspeed, yplace  out  WIDTH each  committed parameter registers.
- upd_strobe  out  4  one-cycle write pulse; bit0 xspeed, bit1 xplace, bit2 yspeed, bit3 yplace.
- entry_val  out  WIDTH  value being typed, for display.
- target  out  2  currently selected register index.
- state  out  2  IDLE=0, ENTRY=1, COMMIT=2.
- err  out  1  one-cycle pulse on a rejected key or an abort.

## Operation
- Reset values: all four parameters 0, upd_strobe 0, entry_val 0, target 0, state IDLE, err 0, internal digit_cnt 0.
- IDLE:
  - Key 10–13: set target to code−10, clear entry_val and digit_cnt, go to ENTRY.
  - Digit or enter: pulse err and stay in IDLE.
  - Clear: no effect.
- ENTRY:
  - Digit d with digit_cnt < DIGITS: entry_val ← entry_val×10 + d (computed at WIDTH+4 bits, truncated to WIDTH) and digit_cnt increments.
  - Digit with digit_cnt = DIGITS: ignored, err pulses.
  - Key 10–13: retarget, clear entry_val and digit_cnt, stay in ENTRY.
  - Clear: zero entry_val and digit_cnt, stay in ENTRY.
  - Enter with digit_cnt ≥ 1: go to COMMIT.
  - Enter with digit_cnt = 0: pulse err, go to IDLE, no write.
- COMMIT (exactly one cycle):
  - The selected register ← min(entry_val, MAX_VAL).
  - The matching upd_strobe bit pulses, then state returns to IDLE with entry_val cleared.
  - A key_valid arriving during COMMIT is dropped and err pulses.
- Unselected registers never change. At most one upd_strobe bit is ever high.

## Timing
- Key sampled at edge E0: entry_val, target, state and err all reflect it in the cycle after E0.
- Enter sampled at E0: state=COMMIT after E0. At E1 the register takes the new value, upd_strobe is high for the one cycle after E1, and state=IDLE. The parameter value and the strobe are visible together.
- Key-to-parameter latency is 2 cycles from the enter pulse.
- Back-to-back key_valid pulses on consecutive cycles are each processed, except a key in the COMMIT cycle, which is dropped as above.
- Reset asserted mid-entry or in COMMIT aborts immediately: no write, no strobe, and all outputs take their reset values asynchronously.

## Configuration
- KEYPAD_TIMEOUT_EN defined:
  - A counter runs while in ENTRY and restarts on every key_valid.
  - When it reaches TIMEOUT_CYC−1 with no key, state goes to IDLE, entry_val clears, err pulses, and no write occurs.
  - A key arriving in the same cycle as expiry wins, and the counter restarts.
- KEYPAD_TIMEOUT_EN undefined: no counter is instantiated, and ENTRY persists indefinitely.

## Test plan
- After reset, keys 10, 1, 2, 5, 15 → xspeed=125, upd_strobe=0001 for one cycle exactly 2 cycles after enter. Other registers stay 0.
- Keys 13, 9, 9, 9, 7 (fourth digit), 15 → err pulse on the 7, then yplace=999 and upd_strobe=1000.
- With MAX_VAL=500: keys 11, 8, 0, 0, 15 → xplace=500 (saturated).
- Keys 12, 4, 14, 6, 15 → yspeed=6; and keys 12, 15 → err pulse, no strobe, state IDLE.
- Keys 10, 3, then reset pulsed low for 1 cycle, then 15 → xspeed stays 0, err pulses (enter in IDLE), no strobe.
- With KEYPAD_TIMEOUT_EN and TIMEOUT_CYC=20: keys 10, 7, then 20 idle cycles → err pulse, state IDLE, xspeed unchanged.

Source files
------------

// File: rtl/keypad_param_loader.sv
// Keypad select/digits/enter dialogue that commits a decimal value to one of four
// parameter registers. Optional ENTRY idle timeout: define KEYPAD_TIMEOUT_EN.
module keypad_param_loader #(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned MAX_VAL     = 999,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] xspeed,
  output logic [WIDTH-1:0] xplace,
  output logic [WIDTH-1:0] yspeed,
  output logic [WIDTH-1:0] yplace,
  output logic [3:0]       upd_strobe,
  output logic [WIDTH-1:0] entry_val,
  output logic [1:0]       target,
  output logic [1:0]       state,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);

  state_t                  state_q, state_d;
  logic [3:0][WIDTH-1:0]   param_q, param_d;
  logic [3:0]              upd_strobe_q, upd_strobe_d;
  logic [WIDTH-1:0]        entry_val_q, entry_val_d;
  logic [1:0]              target_q, target_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        digit_cnt_q, digit_cnt_d;

  logic                    is_digit, is_sel, is_clr;
  logic [1:0]              sel_idx;
  logic [WIDTH+3:0]        acc;
  logic [WIDTH-1:0]        sat_val;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  assign is_digit = (key_code <= 4'd9);
  assign is_sel   = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_clr   = (key_code == 4'd14);
  assign sel_idx  = 2'(key_code - 4'd10);
  assign acc      = {4'b0000, entry_val_q} * (WIDTH+4)'(10) + (WIDTH+4)'(key_code);
  assign sat_val  = (entry_val_q > MAX_W) ? MAX_W : entry_val_q;

  always_comb begin
    state_d      = state_q;
    param_d      = param_q;
    upd_strobe_d = '0;
    entry_val_d  = entry_val_q;
    target_d     = target_q;
    err_d        = 1'b0;
    digit_cnt_d  = digit_cnt_q;
`ifdef KEYPAD_TIMEOUT_EN
    timer_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          if (is_sel) begin
            target_d    = sel_idx;
            entry_val_d = '0;
            digit_cnt_d = '0;
            state_d     = S_ENTRY;
          end else if (!is_clr) begin
            err_d = 1'b1;
          end
        end
      end
      S_ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            if (digit_cnt_q < DIGITS_C) begin
              entry_val_d = acc[WIDTH-1:0];
              digit_cnt_d = digit_cnt_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (is_sel) begin
            target_d    = sel_idx;
            entry_val_d = '0;
            digit_cnt_d = '0;
          end else if (is_clr) begin
            entry_val_d = '0;
            digit_cnt_d = '0;
          end else if (digit_cnt_q != '0) begin
            state_d = S_COMMIT;
          end else begin
            err_d       = 1'b1;
            entry_val_d = '0;
            state_d     = S_IDLE;
          end
        end
`ifdef KEYPAD_TIMEOUT_EN
        // Timer restarts on any key; a key in the expiry cycle takes precedence.
        else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d       = 1'b1;
          entry_val_d = '0;
          digit_cnt_d = '0;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      S_COMMIT: begin
        param_d[target_q]      = sat_val;
        upd_strobe_d[target_q] = 1'b1;
        entry_val_d            = '0;
        digit_cnt_d            = '0;
        state_d                = S_IDLE;
        err_d                  = key_valid;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      param_q      <= '0;
      upd_strobe_q <= '0;
      entry_val_q  <= '0;
      target_q     <= '0;
      err_q        <= 1'b0;
      digit_cnt_q  <= '0;
`ifdef KEYPAD_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      param_q      <= param_d;
      upd_strobe_q <= upd_strobe_d;
      entry_val_q  <= entry_val_d;
      target_q     <= target_d;
      err_q        <= err_d;
      digit_cnt_q  <= digit_cnt_d;
`ifdef KEYPAD_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign xspeed     = param_q[0];
  assign xplace     = param_q[1];
  assign yspeed     = param_q[2];
  assign yplace     = param_q[3];
  assign upd_strobe = upd_strobe_q;
  assign entry_val  = entry_val_q;
  assign target     = target_q;
  assign state      = state_q;
  assign err        = err_q;

endmodule

// File: tb/tb_keypad_param_loader.sv
// Bench for keypad_param_loader: directed dialogues then random keys, checked every
// cycle against a digit-queue model; two instances differ only in MAX_VAL.
module tb_keypad_param_loader;

  localparam int unsigned W    = 10;
  localparam int unsigned TOUT = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_valid = 1'b0;
  logic [3:0] key_code = '0;

  logic [W-1:0] par_a [4];
  logic [W-1:0] par_b [4];
  logic [3:0]   strobe_a, strobe_b;
  logic [W-1:0] ev_a, ev_b;
  logic [1:0]   tgt_a, tgt_b, st_a, st_b;
  logic         err_a, err_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  keypad_param_loader #(.WIDTH(W), .DIGITS(3), .MAX_VAL(999), .TIMEOUT_CYC(TOUT)) dut_a (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .xspeed(par_a[0]), .xplace(par_a[1]), .yspeed(par_a[2]), .yplace(par_a[3]),
    .upd_strobe(strobe_a), .entry_val(ev_a), .target(tgt_a), .state(st_a), .err(err_a)
  );

  keypad_param_loader #(.WIDTH(W), .DIGITS(3), .MAX_VAL(500), .TIMEOUT_CYC(TOUT)) dut_b (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .xspeed(par_b[0]), .xplace(par_b[1]), .yspeed(par_b[2]), .yplace(par_b[3]),
    .upd_strobe(strobe_b), .entry_val(ev_b), .target(tgt_b), .state(st_b), .err(err_b)
  );

  // Model: dialogue mode, typed digits kept as a list, committed values per instance.
  int m_mode;
  int m_tgt;
  int m_digs[$];
  int m_par_a[4];
  int m_par_b[4];
  int m_strobe;
  int m_err;
  int m_idle;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int typed_value();
    int v = 0;
    foreach (m_digs[i]) v = v * 10 + m_digs[i];
    return v;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_tgt = 0; m_digs.delete(); m_strobe = -1; m_err = 0; m_idle = 0;
    for (int i = 0; i < 4; i++) begin
      m_par_a[i] = 0;
      m_par_b[i] = 0;
    end
  endtask

  task automatic model_step(input bit kv, input int kc);
    int v;
    m_strobe = -1;
    m_err = 0;
    case (m_mode)
      0: if (kv) begin
        if (kc >= 10 && kc <= 13) begin
          m_tgt = kc - 10; m_digs.delete(); m_mode = 1; m_idle = 0;
        end else if (kc != 14) m_err = 1;
      end
      1: if (kv) begin
        m_idle = 0;
        if (kc <= 9) begin
          if (m_digs.size() < 3) m_digs.push_back(kc);
          else m_err = 1;
        end else if (kc <= 13) begin
          m_tgt = kc - 10; m_digs.delete();
        end else if (kc == 14) begin
          m_digs.delete();
        end else if (m_digs.size() > 0) begin
          m_mode = 2;
        end else begin
          m_err = 1; m_mode = 0;
        end
      end else begin
`ifdef KEYPAD_TIMEOUT_EN
        m_idle++;
        if (m_idle == TOUT) begin
          m_mode = 0; m_digs.delete(); m_err = 1; m_idle = 0;
        end
`endif
      end
      default: begin
        v = typed_value();
        m_par_a[m_tgt] = min_int(v, 999);
        m_par_b[m_tgt] = min_int(v, 500);
        m_strobe = m_tgt;
        m_mode = 0;
        m_digs.delete();
        m_err = kv ? 1 : 0;
      end
    endcase
  endtask

  task automatic check_all();
    int exp_strobe;
    int exp_ev;
    exp_strobe = (m_strobe < 0) ? 0 : (1 << m_strobe);
    exp_ev = (m_mode == 0) ? 0 : typed_value();
    check("state", st_a, m_mode);
    check("target", tgt_a, m_tgt);
    check("entry_val", ev_a, exp_ev);
    check("err", err_a, m_err);
    check("strobe", strobe_a, exp_strobe);
    check("strobe_b", strobe_b, exp_strobe);
    check("err_b", err_b, m_err);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("param_a%0d", i), par_a[i], m_par_a[i]);
      check($sformatf("param_b%0d", i), par_b[i], m_par_b[i]);
    end
  endtask

  task automatic cycle(input bit kv, input int kc);
    @(negedge clk);
    key_valid = kv;
    key_code  = 4'(kc);
    @(posedge clk);
    model_step(kv, kc);
    #1;
    check_all();
  endtask

  task automatic key(input int kc);
    cycle(1'b1, kc);
    cycle(1'b0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    key_valid = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    #12;
    reset = 1'b1;
    idle(2);

    // xspeed = 125, strobe two cycles after enter
    key(10); key(1); key(2); key(5);
    cycle(1'b1, 15);
    check("plan_commit_state", st_a, 2);
    cycle(1'b0, 0);
    check("plan_xspeed", par_a[0], 125);
    check("plan_strobe", strobe_a, 4'b0001);
    idle(2);

    // fourth digit rejected, yplace saturates at ceiling 999 / 500
    key(13); key(9); key(9); key(9);
    cycle(1'b1, 7);
    check("plan_4th_digit_err", err_a, 1);
    idle(1);
    key(15);
    check("plan_yplace", par_a[3], 999);
    check("plan_yplace_sat", par_b[3], 500);

    // saturation on the MAX_VAL=500 instance
    key(11); key(8); key(0); key(0); key(15);
    check("plan_xplace_sat", par_b[1], 500);
    check("plan_xplace", par_a[1], 800);

    // clear mid-entry, then empty enter
    key(12); key(4); key(14); key(6); key(15);
    check("plan_yspeed", par_a[2], 6);
    key(12);
    cycle(1'b1, 15);
    check("plan_empty_enter_err", err_a, 1);
    idle(1);

    // back-to-back keys, key dropped during commit
    cycle(1'b1, 10); cycle(1'b1, 4); cycle(1'b1, 2); cycle(1'b1, 15);
    cycle(1'b1, 10);
    check("commit_drop_err", err_a, 1);
    idle(2);

    // reset mid-entry aborts the dialogue
    do_reset();
    key(10); key(3);
    do_reset();
    key(15);
    check("reset_xspeed", par_a[0], 0);

    // idle ENTRY: aborts with timeout enabled, persists otherwise
    key(10); key(7);
    idle(TOUT + 5);
`ifdef KEYPAD_TIMEOUT_EN
    check("timeout_state", st_a, 0);
`else
    check("no_timeout_state", st_a, 1);
`endif
    key(14);

    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 399) do_reset();
      else if (n % 150 == 149) idle(TOUT + 2);
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
